// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the HI/LO multiply/divide unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    // Divide by zero: every quotient bit is this value; remainder returns the dividend.
    localparam logic DIV0_QUO_BIT = 1'b1;

    function automatic logic is_iterative(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - shared accumulator/remainder datapath with sign fix-up
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    // acc holds {partial product} for multiply and {remainder, quotient} for divide.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               div_mode;
    logic               neg_main;
    logic               neg_rem;
    logic               b_zero;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic               fits;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] div_next;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign a_neg = is_signed & srca[WIDTH-1];
    assign b_neg = is_signed & srcb[WIDTH-1];
    assign a_mag = a_neg ? (~srca + 1'b1) : srca;
    assign b_mag = b_neg ? (~srcb + 1'b1) : srcb;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    end

    // Remainder is always below the divisor, so the difference fits in WIDTH bits.
    always_comb begin
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        fits     = (rem_sh >= {1'b0, opnd});
        rem_next = fits ? (rem_sh[WIDTH-1:0] - opnd) : rem_sh[WIDTH-1:0];
        div_next = {rem_next, acc[WIDTH-2:0], fits};
    end

    always_comb begin
        prod_fix = neg_main ? (~acc + 1'b1) : acc;
        quo_fix  = neg_main ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
        if (div_mode) begin
            res_hi = rem_fix;
            res_lo = b_zero ? {WIDTH{DIV0_QUO_BIT}} : quo_fix;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            b_zero   <= 1'b0;
        end else if (load) begin
            acc      <= is_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            opnd     <= is_div ? b_mag : a_mag;
            div_mode <= is_div;
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            b_zero   <= (srcb == '0);
        end else if (step) begin
            acc <= div_mode ? div_next : mul_next;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO multiply/divide sequencer, HI/LO registers and pipeline stall
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush_e,
    input  logic             hilo_rd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall
);

    md_state_t        state;
    logic [CNT_W-1:0] counter;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    assign accept = (state == IDLE) && (op != MD_NONE) && !flush_e;
    assign load   = accept && is_iterative(op);
    assign stall  = busy && (hilo_rd || (op != MD_NONE));

    muldiv_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (state == CALC),
        .is_div   (is_div_op(op)),
        .is_signed(is_signed_op(op)),
        .srca     (srca),
        .srcb     (srcb),
        .res_hi   (res_hi),
        .res_lo   (res_lo)
    );

    // busy tracks the next state so it is a registered decode of state != IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op == MD_MTHI) begin
                            hi <= srca;
                        end else if (op == MD_MTLO) begin
                            lo <= srca;
                        end else if (is_iterative(op)) begin
                            state   <= CALC;
                            busy    <= 1'b1;
                            counter <= CNT_W'(WIDTH - 1);
                        end
                    end
                end
                CALC: begin
                    if (counter == '0) begin
                        state <= FIX;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl against an arithmetic reference model
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk;
    logic        reset;
    md_op_t      op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        flush_e;
    logic        hilo_rd;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    int          checks;
    int          failures;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    muldiv_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .op     (op),
        .srca   (srca),
        .srcb   (srcb),
        .flush_e(flush_e),
        .hilo_rd(hilo_rd),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .stall  (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] rh, output logic [31:0] rl);
        longint p;
        longint q;
        longint r;
        longint sa;
        longint sb;
        rh = 32'h0;
        rl = 32'h0;
        if (o == MD_MULT || o == MD_DIV) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        if (o == MD_MULT || o == MD_MULTU) begin
            p  = sa * sb;
            rh = p[63:32];
            rl = p[31:0];
        end else if (b == 32'h0) begin
            rh = a;
            rl = 32'hFFFF_FFFF;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            rh = r[31:0];
            rl = q[31:0];
        end
    endfunction

    task automatic run_op(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                          input bit flush_mid, input string tag);
        logic [31:0] eh;
        logic [31:0] el;
        int          n;
        bit          early;
        model(o, a, b, eh, el);
        @(negedge clk);
        op = o; srca = a; srcb = b; flush_e = 1'b0;
        @(negedge clk);
        op = MD_NONE; srca = $urandom; srcb = $urandom;
        #1;
        n = 0;
        early = 0;
        while (busy && n < 40) begin
            n++;
            if (hi !== exp_hi || lo !== exp_lo) early = 1;
            if (flush_mid) flush_e = 1'($urandom_range(0, 1));
            @(negedge clk);
            #1;
        end
        flush_e = 1'b0;
        check({tag, "_busy_cycles"}, 32'(n), 32'd33);
        check({tag, "_hilo_held"}, 32'(early), 32'd0);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        exp_hi = eh;
        exp_lo = el;
    endtask

    initial begin
        int n;
        md_op_t ro;
        logic [31:0] ra;
        logic [31:0] rb;
        checks = 0; failures = 0;
        exp_hi = 32'h0; exp_lo = 32'h0;
        reset = 1'b1; op = MD_NONE; srca = 32'h0; srcb = 32'h0; flush_e = 1'b0; hilo_rd = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        reset = 1'b0;

        run_op(MD_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0, "mult_7_m3");
        check("mult_7_m3_hi_const", hi, 32'hFFFF_FFFF);
        check("mult_7_m3_lo_const", lo, 32'hFFFF_FFEB);
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        check("multu_max_hi_const", hi, 32'hFFFF_FFFE);
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
        check("div_m7_2_lo_const", lo, 32'hFFFF_FFFD);
        run_op(MD_DIVU, 32'h64, 32'h0, 1'b0, "divu_by0");
        check("divu_by0_lo_const", lo, 32'hFFFF_FFFF);
        run_op(MD_DIV, 32'hFFFF_FFF6, 32'h0, 1'b0, "div_neg_by0");
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        check("div_ovf_lo_const", lo, 32'h8000_0000);

        // MFLO/MFHI held behind a running divide
        @(negedge clk);
        op = MD_DIV; srca = 32'd100; srcb = 32'd7;
        @(negedge clk);
        op = MD_NONE; hilo_rd = 1'b1;
        #1;
        n = 0;
        while (stall && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("mfhilo_stall_cycles", 32'(n), 32'd33);
        check("mflo_read", lo, 32'd14);
        check("mfhi_read", hi, 32'd2);
        hilo_rd = 1'b0;

        // A second op held during busy is accepted on the first IDLE edge
        @(negedge clk);
        op = MD_DIV; srca = 32'd100; srcb = 32'd7;
        @(negedge clk);
        op = MD_MULT; srca = 32'd3; srcb = 32'd4;
        #1;
        n = 0;
        while (stall && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("held_mult_stall_cycles", 32'(n), 32'd33);
        check("held_mult_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        check("held_mult_accepted", 32'(busy), 32'd1);
        op = MD_NONE;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("held_mult_busy_rest", 32'(n), 32'd33);
        check("held_mult_lo", lo, 32'd12);
        check("held_mult_hi", hi, 32'd0);
        exp_hi = 32'd0; exp_lo = 32'd12;

        // MTLO with and without flush; MULT under flush is ignored
        @(negedge clk);
        op = MD_MTLO; srca = 32'h1234; flush_e = 1'b1;
        @(negedge clk);
        #1;
        check("mtlo_flushed_lo", lo, exp_lo);
        flush_e = 1'b0;
        @(negedge clk);
        #1;
        check("mtlo_lo", lo, 32'h1234);
        check("mtlo_busy", 32'(busy), 32'd0);
        check("mtlo_stall", 32'(stall), 32'd0);
        op = MD_MTHI; srca = 32'hABCD_0001;
        @(negedge clk);
        op = MD_MULT; srca = 32'd9; srcb = 32'd9; flush_e = 1'b1;
        #1;
        check("mthi_hi", hi, 32'hABCD_0001);
        @(negedge clk);
        #1;
        check("flushed_mult_busy", 32'(busy), 32'd0);
        op = MD_NONE; flush_e = 1'b0;
        exp_hi = 32'hABCD_0001; exp_lo = 32'h1234;

        // Reset mid-calculation abandons the op
        @(negedge clk);
        op = MD_MULT; srca = 32'd5; srcb = 32'd6;
        @(negedge clk);
        op = MD_NONE;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hilo_rd = 1'b1;
        #1;
        check("midreset_hi", hi, 32'h0);
        check("midreset_lo", lo, 32'h0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_stall", 32'(stall), 32'd0);
        hilo_rd = 1'b0;
        exp_hi = 32'h0; exp_lo = 32'h0;
        run_op(MD_MULT, 32'd5, 32'd6, 1'b0, "mult_5_6");

        for (int i = 0; i < 16; i++) begin
            ro = md_op_t'($urandom_range(1, 4));
            ra = $urandom;
            rb = (i % 5 == 0) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            run_op(ro, ra, rb, 1'(i % 2), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
